// File: rtl/password_checker_if.sv
// Keypad/command bus between the lock-sequence controller (master) and the
// password checker (slave). Carries the entry commands, digits and result flags.
interface password_checker_if #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic               set_pw;
  logic               test_pw;
  logic               digit_vld;
  logic [DIGIT_W-1:0] digit;
  logic               enter;
  logic               gled1;
  logic               rled2;
  logic               err;
  logic               pw_valid;
  logic [2:0]         tries_left;
  logic [CW-1:0]      cnt;

  modport master (
    output set_pw, test_pw, digit_vld, digit, enter,
    input  gled1, rled2, err, pw_valid, tries_left, cnt
  );

  modport slave (
    input  set_pw, test_pw, digit_vld, digit, enter,
    output gled1, rled2, err, pw_valid, tries_left, cnt
  );
endinterface

// File: rtl/password_checker.sv
// Password store/verify engine for the lock.
// Collects keypad digits, stores a password on set, compares on test, and
// locks out permanently (until reset) after MAX_TRIES consecutive failures.
// Optional feature: define PWD_TIMEOUT_EN to abort entries that sit idle for
// TIMEOUT_CYC cycles (a timed-out verify counts as a mismatch).
module password_checker #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  password_checker_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int EW = DIGITS * DIGIT_W;
  localparam logic [CW-1:0] FULL   = CW'(DIGITS);
  localparam logic [2:0]    TRIES0 = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE, SET_ENT, TST_ENT, CMP, MATCH, LOCKED
  } state_t;

  state_t        state_q;
  logic [EW-1:0] entry_q;
  logic [EW-1:0] pw_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    tries_q;
  logic          gled_q;
  logic          rled_q;
  logic          err_q;
  logic          pw_valid_q;

  logic start_set_d;
  logic start_tst_d;
  logic cmd_ok;
  logic in_entry;
  logic pw_match;

  // Command decode: set_pw outranks test_pw; both (re)start an entry from any
  // non-busy state, test_pw only once a password exists.
  always_comb begin
    cmd_ok      = (state_q == IDLE) || (state_q == MATCH) ||
                  (state_q == SET_ENT) || (state_q == TST_ENT);
    in_entry    = (state_q == SET_ENT) || (state_q == TST_ENT);
    start_set_d = cmd_ok && bus.set_pw;
    start_tst_d = cmd_ok && !bus.set_pw && bus.test_pw && pw_valid_q;
    // A short entry can never match, even if the zero-padded value agrees.
    pw_match    = (cnt_q == FULL) && (entry_q == pw_q);
  end

`ifdef PWD_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
  logic [IW-1:0] idle_q;

  // Idle counter: cleared on entry start and on each digit, advances otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          idle_q <= '0;
    else if (start_set_d || start_tst_d) idle_q <= '0;
    else if (in_entry && bus.digit_vld)  idle_q <= '0;
    else if (in_entry && !bus.enter)     idle_q <= (idle_q == IDLE_LAST) ? '0 : idle_q + 1'b1;
    else                                 idle_q <= '0;
  end
`else
  wire unused_timeout = |TIMEOUT_CYC;
`endif

  // Main FSM with registered result flags; err defaults low so it pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      entry_q    <= '0;
      pw_q       <= '0;
      cnt_q      <= '0;
      tries_q    <= TRIES0;
      gled_q     <= 1'b0;
      rled_q     <= 1'b0;
      err_q      <= 1'b0;
      pw_valid_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (start_set_d || start_tst_d) begin
        state_q <= start_set_d ? SET_ENT : TST_ENT;
        cnt_q   <= '0;
        entry_q <= '0;
        gled_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // test_pw with nothing stored is rejected
            if (bus.test_pw) err_q <= 1'b1;
          end
          SET_ENT, TST_ENT: begin
            if (bus.enter) begin
              if (state_q == TST_ENT) begin
                state_q <= CMP;
              end else begin
                state_q <= IDLE;
                if (cnt_q == FULL) begin
                  pw_q       <= entry_q;
                  pw_valid_q <= 1'b1;
                  tries_q    <= TRIES0;
                end else begin
                  err_q <= 1'b1;
                end
              end
            end else if (bus.digit_vld) begin
              // digits past the last slot are dropped, not wrapped
              if (cnt_q != FULL) begin
                entry_q <= (entry_q << DIGIT_W) | EW'(bus.digit);
                cnt_q   <= cnt_q + 1'b1;
              end
            end
`ifdef PWD_TIMEOUT_EN
            else if (idle_q == IDLE_LAST) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
              if (state_q == TST_ENT) begin
                tries_q <= tries_q - 1'b1;
                if (tries_q == 3'd1) begin
                  state_q <= LOCKED;
                  rled_q  <= 1'b1;
                end
              end
            end
`endif
          end
          CMP: begin
            if (pw_match) begin
              state_q <= MATCH;
              gled_q  <= 1'b1;
              tries_q <= TRIES0;
            end else begin
              err_q   <= 1'b1;
              tries_q <= tries_q - 1'b1;
              if (tries_q == 3'd1) begin
                state_q <= LOCKED;
                rled_q  <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          MATCH: ;
          LOCKED: begin
            rled_q <= 1'b1;
            gled_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.gled1      = gled_q;
  assign bus.rled2      = rled_q;
  assign bus.err        = err_q;
  assign bus.pw_valid   = pw_valid_q;
  assign bus.tries_left = tries_q;
  assign bus.cnt        = cnt_q;
endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker (DIGITS=4, MAX_TRIES=3, TIMEOUT_CYC=16).
// Expected output snapshots {gled1,rled2,err,pw_valid,tries_left,cnt} are
// queued as stimulus is driven and popped when the DUT result is due.
module tb_password_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  password_checker_if #(.DIGITS(4), .DIGIT_W(4)) pif ();

  password_checker #(
    .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .TIMEOUT_CYC(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (pif)
  );

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [9:0] pk(input logic g, input logic r, input logic e,
                                    input logic pv, input logic [2:0] t,
                                    input logic [2:0] c);
    return {g, r, e, pv, t, c};
  endfunction

  task automatic push(input string tag, input logic [9:0] v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  task automatic pop();
    exp_t       x;
    logic [9:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty got none want entry");
    end else begin
      x   = sb.pop_front();
      obs = {pif.gled1, pif.rled2, pif.err, pif.pw_valid, pif.tries_left, pif.cnt};
      assert (obs === x.v) else begin
        errors++;
        $error("FAIL %s got %b want %b", x.tag, obs, x.v);
      end
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_set();  pif.set_pw  = 1'b1; cyc(); pif.set_pw  = 1'b0; endtask
  task automatic do_tst();  pif.test_pw = 1'b1; cyc(); pif.test_pw = 1'b0; endtask
  task automatic do_ent();  pif.enter   = 1'b1; cyc(); pif.enter   = 1'b0; endtask

  task automatic dg(input logic [3:0] v);
    pif.digit_vld = 1'b1;
    pif.digit     = v;
    cyc();
    pif.digit_vld = 1'b0;
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    dg(a); dg(b); dg(c); dg(d);
  endtask

  // enter, then the CMP cycle and the result cycle
  task automatic verify(input string tag, input logic [9:0] cmp_v, input logic [9:0] res_v);
    push({tag, "_cmp"}, cmp_v);
    push(tag, res_v);
    do_ent(); pop();
    cyc();    pop();
  endtask

  initial begin
    pif.set_pw = 1'b0; pif.test_pw = 1'b0; pif.digit_vld = 1'b0;
    pif.digit  = '0;   pif.enter   = 1'b0;
    cyc(2);
    push("reset", pk(0,0,0,0,3,0)); pop();
    rst_n = 1'b1;
    cyc();

    // test with no password, then a short set
    do_tst(); push("nopw_err", pk(0,0,1,0,3,0)); pop();
    cyc();    push("nopw_idle", pk(0,0,0,0,3,0)); pop();
    do_set(); dg(9); dg(9);
    push("short_cnt", pk(0,0,0,0,3,2)); pop();
    do_ent(); push("short_set_err", pk(0,0,1,0,3,2)); pop();

    // store 1234, verify it
    do_set(); code4(1,2,3,4);
    push("set_full", pk(0,0,0,0,3,4)); pop();
    do_ent(); push("set_store", pk(0,0,0,1,3,4)); pop();
    do_tst(); code4(1,2,3,4);
    verify("match1234", pk(0,0,0,1,3,4), pk(1,0,0,1,3,4));

    // one wrong, then right
    do_tst(); push("gled_drop", pk(0,0,0,1,3,0)); pop();
    code4(1,2,3,5);
    verify("mismatch", pk(0,0,0,1,3,4), pk(0,0,1,1,2,4));
    cyc(); push("err_pulse_end", pk(0,0,0,1,2,4)); pop();
    do_tst(); code4(1,2,3,4);
    verify("rematch", pk(0,0,0,1,2,4), pk(1,0,0,1,3,4));

    // enter with a digit in the same cycle: digit dropped, short entry mismatches
    do_tst(); dg(5); dg(6); dg(7);
    pif.enter = 1'b1; pif.digit_vld = 1'b1; pif.digit = 4'd8;
    push("ent_dig_cmp", pk(0,0,0,1,3,3));
    push("ent_dig_mismatch", pk(0,0,1,1,2,3));
    cyc(); pop();
    pif.enter = 1'b0; pif.digit_vld = 1'b0;
    cyc(); pop();
    do_tst(); code4(1,2,3,4);
    verify("restore", pk(0,0,0,1,2,4), pk(1,0,0,1,3,4));

    // reprogram from MATCH with an extra digit; restart a test mid-entry
    do_set(); push("set_from_match", pk(0,0,0,1,3,0)); pop();
    code4(5,6,7,8); dg(9);
    push("fifth_dropped", pk(0,0,0,1,3,4)); pop();
    do_ent(); push("store5678", pk(0,0,0,1,3,4)); pop();
    do_tst(); dg(1); dg(2);
    do_tst(); push("restart_cnt", pk(0,0,0,1,3,0)); pop();
    code4(5,6,7,8);
    verify("match5678", pk(0,0,0,1,3,4), pk(1,0,0,1,3,4));

    // three failures lock out
    for (int k = 0; k < 3; k++) begin
      do_tst(); code4(1,1,1,1);
      verify("lock_seq", pk(0,0,0,1,3'(3-k),4),
             (k == 2) ? pk(0,1,1,1,0,4) : pk(0,0,1,1,3'(2-k),4));
    end
    cyc(); push("locked_hold", pk(0,1,0,1,0,4)); pop();
    do_tst(); code4(5,6,7,8); do_ent(); cyc();
    push("locked_ignore", pk(0,1,0,1,0,4)); pop();
    do_set(); push("locked_ignore_set", pk(0,1,0,1,0,4)); pop();
    rst_n = 1'b0; #1;
    push("async_reset", pk(0,0,0,0,3,0)); pop();
    cyc(); rst_n = 1'b1; cyc();
    do_tst(); push("pw_lost", pk(0,0,1,0,3,0)); pop();

    // idle entry behaviour
    do_set(); code4(1,2,3,4); do_ent();
    push("store_again", pk(0,0,0,1,3,4)); pop();
    do_tst(); push("idle_start", pk(0,0,0,1,3,0)); pop();
`ifdef PWD_TIMEOUT_EN
    cyc(15); push("pre_timeout", pk(0,0,0,1,3,0)); pop();
    cyc();   push("timeout", pk(0,0,1,1,2,0)); pop();
`else
    cyc(10000); push("still_pending", pk(0,0,0,1,3,0)); pop();
    code4(1,2,3,4);
    verify("late_match", pk(0,0,0,1,3,4), pk(1,0,0,1,3,4));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
